// File: rtl/pipe_ctrl_unit.sv
// Control path for a 5-stage RV32I pipeline: ID decode, ID/EX, EX/MEM and MEM/WB control
// registers, load-use stall, EX-stage redirect with flush, forwarding selects, stall counter.
module pipe_ctrl_unit #(
  parameter int REG_AW = 5,
  parameter bit EN_BNE = 1'b1,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [6:0]        id_opcode_i,
  input  logic [2:0]        id_func3_i,
  input  logic [6:0]        id_func7_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              ex_zero_i,
  output logic              stall_o,
  output logic              ifid_flush_o,
  output logic [1:0]        ex_pcsrc_o,
  output logic [2:0]        ex_aluop_o,
  output logic              ex_alusrc_o,
  output logic [1:0]        fwd_a_o,
  output logic [1:0]        fwd_b_o,
  output logic              mem_memread_o,
  output logic              mem_memwrite_o,
  output logic              wb_regwrite_o,
  output logic [1:0]        wb_memtoreg_o,
  output logic [REG_AW-1:0] ex_rd_o,
  output logic [REG_AW-1:0] mem_rd_o,
  output logic [REG_AW-1:0] wb_rd_o,
  output logic              illegal_o,
  output logic [CNT_W-1:0]  stall_count_o
);

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;
  localparam logic [2:0] ALU_SLT = 3'd5;
  localparam logic [2:0] ALU_SLL = 3'd6;
  localparam logic [2:0] ALU_SRL = 3'd7;

  typedef struct packed {
    logic [2:0] aluop;
    logic       alusrc;
    logic       memread;
    logic       memwrite;
    logic       regwrite;
    logic [1:0] memtoreg;
    logic       beq;
    logic       bne;
    logic       jal;
    logic       jalr;
  } ctrl_t;

  ctrl_t             idCtrl;
  logic              idIllegal;
  logic [2:0]        arithAlu;
  logic              take;
  logic              loadUse;
  logic              stall;

  ctrl_t             exCtrl_q, exCtrl_d;
  logic [REG_AW-1:0] exRs1_q, exRs1_d, exRs2_q, exRs2_d, exRd_q, exRd_d;
  logic              memMemread_q, memMemwrite_q, memRegwrite_q;
  logic [1:0]        memMemtoreg_q;
  logic [REG_AW-1:0] memRd_q;
  logic              wbRegwrite_q;
  logic [1:0]        wbMemtoreg_q;
  logic [REG_AW-1:0] wbRd_q;
  logic [CNT_W-1:0]  stallCnt_q, stallCnt_d;

  // func3 selects the ALU op for R and I formats; only R uses func7[5] for SUB
  always_comb begin
    arithAlu = ALU_ADD;
    case (id_func3_i)
      3'b000:  arithAlu = (id_opcode_i == OP_R && id_func7_i[5]) ? ALU_SUB : ALU_ADD;
      3'b111:  arithAlu = ALU_AND;
      3'b110:  arithAlu = ALU_OR;
      3'b100:  arithAlu = ALU_XOR;
      3'b010:  arithAlu = ALU_SLT;
      3'b001:  arithAlu = ALU_SLL;
      3'b101:  arithAlu = ALU_SRL;
      default: arithAlu = ALU_ADD;
    endcase
  end

  always_comb begin
    idCtrl    = '0;
    idIllegal = 1'b0;
    case (id_opcode_i)
      OP_R: begin
        idCtrl.aluop    = arithAlu;
        idCtrl.regwrite = 1'b1;
      end
      OP_I: begin
        idCtrl.aluop    = arithAlu;
        idCtrl.alusrc   = 1'b1;
        idCtrl.regwrite = 1'b1;
      end
      OP_LW: begin
        idCtrl.alusrc   = 1'b1;
        idCtrl.memread  = 1'b1;
        idCtrl.regwrite = 1'b1;
        idCtrl.memtoreg = 2'b01;
      end
      OP_SW: begin
        idCtrl.alusrc   = 1'b1;
        idCtrl.memwrite = 1'b1;
      end
      OP_BR: begin
        idCtrl.aluop = ALU_SUB;
        if (id_func3_i == 3'b000)                idCtrl.beq = 1'b1;
        else if (EN_BNE && id_func3_i == 3'b001) idCtrl.bne = 1'b1;
        else                                     idIllegal  = 1'b1;
      end
      OP_JAL: begin
        idCtrl.jal      = 1'b1;
        idCtrl.regwrite = 1'b1;
        idCtrl.memtoreg = 2'b10;
      end
      OP_JALR: begin
        idCtrl.jalr     = 1'b1;
        idCtrl.alusrc   = 1'b1;
        idCtrl.regwrite = 1'b1;
        idCtrl.memtoreg = 2'b10;
      end
      default: idIllegal = 1'b1;
    endcase
    if (idIllegal) idCtrl = '0;
  end

  // A taken redirect makes the ID instruction wrong-path, so it overrides the load-use stall
  assign take    = (exCtrl_q.beq & ex_zero_i) | (exCtrl_q.bne & ~ex_zero_i) |
                   exCtrl_q.jal | exCtrl_q.jalr;
  assign loadUse = exCtrl_q.memread && (exRd_q != '0) &&
                   ((exRd_q == id_rs1_i) || (exRd_q == id_rs2_i));
  assign stall   = loadUse & ~take;

  always_comb begin
    exCtrl_d          = idCtrl;
    exCtrl_d.regwrite = idCtrl.regwrite & (id_rd_i != '0);
    exRs1_d           = id_rs1_i;
    exRs2_d           = id_rs2_i;
    exRd_d            = id_rd_i;
    if (take || stall || idIllegal) begin
      exCtrl_d = '0;
      exRs1_d  = '0;
      exRs2_d  = '0;
      exRd_d   = '0;
    end
  end

  assign stallCnt_d = (stall && stallCnt_q != {CNT_W{1'b1}}) ? stallCnt_q + CNT_W'(1) : stallCnt_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      exCtrl_q      <= '0;
      exRs1_q       <= '0;
      exRs2_q       <= '0;
      exRd_q        <= '0;
      memMemread_q  <= 1'b0;
      memMemwrite_q <= 1'b0;
      memRegwrite_q <= 1'b0;
      memMemtoreg_q <= 2'b00;
      memRd_q       <= '0;
      wbRegwrite_q  <= 1'b0;
      wbMemtoreg_q  <= 2'b00;
      wbRd_q        <= '0;
      stallCnt_q    <= '0;
    end else begin
      exCtrl_q      <= exCtrl_d;
      exRs1_q       <= exRs1_d;
      exRs2_q       <= exRs2_d;
      exRd_q        <= exRd_d;
      memMemread_q  <= exCtrl_q.memread;
      memMemwrite_q <= exCtrl_q.memwrite;
      memRegwrite_q <= exCtrl_q.regwrite;
      memMemtoreg_q <= exCtrl_q.memtoreg;
      memRd_q       <= exRd_q;
      wbRegwrite_q  <= memRegwrite_q;
      wbMemtoreg_q  <= memMemtoreg_q;
      wbRd_q        <= memRd_q;
      stallCnt_q    <= stallCnt_d;
    end
  end

  assign fwd_a_o = (memRegwrite_q && memRd_q != '0 && memRd_q == exRs1_q) ? 2'b10 :
                   (wbRegwrite_q  && wbRd_q  != '0 && wbRd_q  == exRs1_q) ? 2'b01 : 2'b00;
  assign fwd_b_o = (memRegwrite_q && memRd_q != '0 && memRd_q == exRs2_q) ? 2'b10 :
                   (wbRegwrite_q  && wbRd_q  != '0 && wbRd_q  == exRs2_q) ? 2'b01 : 2'b00;

  assign stall_o        = stall;
  assign ifid_flush_o   = take;
  assign ex_pcsrc_o     = exCtrl_q.jalr ? 2'b10 : (take ? 2'b01 : 2'b00);
  assign ex_aluop_o     = exCtrl_q.aluop;
  assign ex_alusrc_o    = exCtrl_q.alusrc;
  assign mem_memread_o  = memMemread_q;
  assign mem_memwrite_o = memMemwrite_q;
  assign wb_regwrite_o  = wbRegwrite_q;
  assign wb_memtoreg_o  = wbMemtoreg_q;
  assign ex_rd_o        = exRd_q;
  assign mem_rd_o       = memRd_q;
  assign wb_rd_o        = wbRd_q;
  assign illegal_o      = idIllegal;
  assign stall_count_o  = stallCnt_q;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Random and directed instruction streams for two pipe_ctrl_unit variants (BNE on/16-bit counter,
// BNE off/2-bit counter), checked every cycle against an instruction-level pipeline model.
module tb_pipe_ctrl_unit;

  localparam int AW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [6:0]    op, f7;
  logic [2:0]    f3;
  logic [AW-1:0] rs1, rs2, rd;
  logic          zero;

  logic          stallA, flushA, illA, alusrcA, mrA, mwA, rwA;
  logic [1:0]    pcsrcA, fwdaA, fwdbA, m2rA;
  logic [2:0]    aluopA;
  logic [AW-1:0] exrdA, memrdA, wbrdA;
  logic [15:0]   cntA;
  logic          stallB, flushB, illB, alusrcB, mrB, mwB, rwB;
  logic [1:0]    pcsrcB, fwdaB, fwdbB, m2rB;
  logic [2:0]    aluopB;
  logic [AW-1:0] exrdB, memrdB, wbrdB;
  logic [1:0]    cntB;

  pipe_ctrl_unit #(.REG_AW(AW), .EN_BNE(1'b1), .CNT_W(16)) dutA (
    .clk_i(clk), .reset_i(rst), .id_opcode_i(op), .id_func3_i(f3), .id_func7_i(f7),
    .id_rs1_i(rs1), .id_rs2_i(rs2), .id_rd_i(rd), .ex_zero_i(zero),
    .stall_o(stallA), .ifid_flush_o(flushA), .ex_pcsrc_o(pcsrcA), .ex_aluop_o(aluopA),
    .ex_alusrc_o(alusrcA), .fwd_a_o(fwdaA), .fwd_b_o(fwdbA), .mem_memread_o(mrA),
    .mem_memwrite_o(mwA), .wb_regwrite_o(rwA), .wb_memtoreg_o(m2rA), .ex_rd_o(exrdA),
    .mem_rd_o(memrdA), .wb_rd_o(wbrdA), .illegal_o(illA), .stall_count_o(cntA));

  pipe_ctrl_unit #(.REG_AW(AW), .EN_BNE(1'b0), .CNT_W(2)) dutB (
    .clk_i(clk), .reset_i(rst), .id_opcode_i(op), .id_func3_i(f3), .id_func7_i(f7),
    .id_rs1_i(rs1), .id_rs2_i(rs2), .id_rd_i(rd), .ex_zero_i(zero),
    .stall_o(stallB), .ifid_flush_o(flushB), .ex_pcsrc_o(pcsrcB), .ex_aluop_o(aluopB),
    .ex_alusrc_o(alusrcB), .fwd_a_o(fwdaB), .fwd_b_o(fwdbB), .mem_memread_o(mrB),
    .mem_memwrite_o(mwB), .wb_regwrite_o(rwB), .wb_memtoreg_o(m2rB), .ex_rd_o(exrdB),
    .mem_rd_o(memrdB), .wb_rd_o(wbrdB), .illegal_o(illB), .stall_count_o(cntB));

  typedef enum int {K_NONE, K_R, K_I, K_LW, K_SW, K_BEQ, K_BNE, K_JAL, K_JALR, K_ILL} kind_e;
  typedef struct {
    kind_e kind;
    int    alu;
    int    rd;
    int    rs1;
    int    rs2;
  } instr_t;

  instr_t mEx[2], mMem[2], mWb[2];
  int     mCnt[2];
  int     cntMax[2] = '{65535, 3};
  bit     bneOk[2]  = '{1'b1, 1'b0};
  bit     holdId;
  int     total = 0;
  int     bad = 0;

  function automatic instr_t bubble();
    instr_t t;
    t.kind = K_NONE; t.alu = 0; t.rd = 0; t.rs1 = 0; t.rs2 = 0;
    return t;
  endfunction

  // ALU op by func3 for arithmetic formats: ADD SLL SLT - XOR SRL OR AND
  function automatic instr_t decode(int o, int f3v, int f7v, int r1, int r2, int rdv, bit bne);
    instr_t t;
    int aluTab[8];
    aluTab = '{0, 6, 5, 0, 4, 7, 3, 2};
    t = bubble();
    case (o)
      'h33: begin t.kind = K_R; t.alu = (f3v == 0 && ((f7v >> 5) & 1) == 1) ? 1 : aluTab[f3v]; end
      'h13: begin t.kind = K_I; t.alu = aluTab[f3v]; end
      'h03: t.kind = K_LW;
      'h23: t.kind = K_SW;
      'h63: begin
        t.alu = 1;
        if (f3v == 0)             t.kind = K_BEQ;
        else if (f3v == 1 && bne) t.kind = K_BNE;
        else                      t.kind = K_ILL;
      end
      'h6F: t.kind = K_JAL;
      'h67: t.kind = K_JALR;
      default: t.kind = K_ILL;
    endcase
    if (t.kind == K_ILL) t.alu = 0;
    else begin t.rd = rdv; t.rs1 = r1; t.rs2 = r2; end
    return t;
  endfunction

  function automatic bit writes(instr_t t);
    return (t.kind inside {K_R, K_I, K_LW, K_JAL, K_JALR}) && t.rd != 0;
  endfunction

  function automatic int fwdOf(int src, instr_t memI, instr_t wbI);
    if (writes(memI) && memI.rd == src) return 2;
    if (writes(wbI) && wbI.rd == src)   return 1;
    return 0;
  endfunction

  function automatic int wbSel(instr_t t);
    if (t.kind == K_LW) return 1;
    if (t.kind == K_JAL || t.kind == K_JALR) return 2;
    return 0;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h want=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic applyStimulus(input bit r, input int o, input int f3v, input int f7v,
                               input int r1, input int r2, input int rdv, input bit z, input bit chk);
    @(negedge clk);
    rst = r; op = 7'(o); f3 = 3'(f3v); f7 = 7'(f7v);
    rs1 = AW'(r1); rs2 = AW'(r2); rd = AW'(rdv); zero = z;
    #1;
    for (int k = 0; k < 2; k++) begin
      instr_t ex, mem, wb, id;
      bit take, stl;
      int pcs;
      string nm;
      nm  = (k == 0) ? "A" : "B";
      ex  = mEx[k]; mem = mMem[k]; wb = mWb[k];
      id  = decode(o, f3v, f7v, r1, r2, rdv, bneOk[k]);
      take = (ex.kind == K_BEQ && z) || (ex.kind == K_BNE && !z) ||
             ex.kind == K_JAL || ex.kind == K_JALR;
      pcs  = (ex.kind == K_JALR) ? 2 : (take ? 1 : 0);
      stl  = ex.kind == K_LW && ex.rd != 0 && (ex.rd == r1 || ex.rd == r2) && !take;
      if (chk) begin
        checkOutput({nm, ".stall"},   k == 0 ? 32'(stallA)  : 32'(stallB),  32'(stl));
        checkOutput({nm, ".flush"},   k == 0 ? 32'(flushA)  : 32'(flushB),  32'(take));
        checkOutput({nm, ".pcsrc"},   k == 0 ? 32'(pcsrcA)  : 32'(pcsrcB),  32'(pcs));
        checkOutput({nm, ".illegal"}, k == 0 ? 32'(illA)    : 32'(illB),    32'(id.kind == K_ILL));
        checkOutput({nm, ".aluop"},   k == 0 ? 32'(aluopA)  : 32'(aluopB),  32'(ex.alu));
        checkOutput({nm, ".alusrc"},  k == 0 ? 32'(alusrcA) : 32'(alusrcB),
                    32'(ex.kind inside {K_I, K_LW, K_SW, K_JALR}));
        checkOutput({nm, ".fwdA"},    k == 0 ? 32'(fwdaA)   : 32'(fwdaB),   32'(fwdOf(ex.rs1, mem, wb)));
        checkOutput({nm, ".fwdB"},    k == 0 ? 32'(fwdbA)   : 32'(fwdbB),   32'(fwdOf(ex.rs2, mem, wb)));
        checkOutput({nm, ".memread"}, k == 0 ? 32'(mrA)     : 32'(mrB),     32'(mem.kind == K_LW));
        checkOutput({nm, ".memwrite"},k == 0 ? 32'(mwA)     : 32'(mwB),     32'(mem.kind == K_SW));
        checkOutput({nm, ".regwrite"},k == 0 ? 32'(rwA)     : 32'(rwB),     32'(writes(wb)));
        checkOutput({nm, ".memtoreg"},k == 0 ? 32'(m2rA)    : 32'(m2rB),    32'(wbSel(wb)));
        checkOutput({nm, ".exRd"},    k == 0 ? 32'(exrdA)   : 32'(exrdB),   32'(ex.rd));
        checkOutput({nm, ".memRd"},   k == 0 ? 32'(memrdA)  : 32'(memrdB),  32'(mem.rd));
        checkOutput({nm, ".wbRd"},    k == 0 ? 32'(wbrdA)   : 32'(wbrdB),   32'(wb.rd));
        checkOutput({nm, ".stallCnt"},k == 0 ? 32'(cntA)    : 32'(cntB),    32'(mCnt[k]));
      end
      if (k == 0) holdId = stl;
      if (r) begin
        mEx[k] = bubble(); mMem[k] = bubble(); mWb[k] = bubble(); mCnt[k] = 0;
      end else begin
        mWb[k]  = mem;
        mMem[k] = ex;
        mEx[k]  = (take || stl || id.kind == K_ILL) ? bubble() : id;
        if (stl && mCnt[k] < cntMax[k]) mCnt[k]++;
      end
    end
  endtask

  // Issue one instruction, re-presenting it while the front end is held by a stall
  task automatic issue(input int o, input int f3v, input int f7v, input int r1, input int r2,
                       input int rdv, input bit z);
    int tries = 0;
    applyStimulus(1'b0, o, f3v, f7v, r1, r2, rdv, z, 1'b1);
    while (holdId && tries < 4) begin
      applyStimulus(1'b0, o, f3v, f7v, r1, r2, rdv, z, 1'b1);
      tries++;
    end
    if (holdId) checkOutput("stallBound", 32'(holdId), 32'd0);
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) issue('h13, 0, 0, 0, 0, 0, 1'b0);
  endtask

  function automatic int pickReg();
    return ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 3));
  endfunction

  initial begin
    int f3Tab[7];
    f3Tab = '{0, 1, 2, 4, 5, 6, 7};
    holdId = 1'b0;
    applyStimulus(1'b1, 'h13, 0, 0, 0, 0, 0, 1'b0, 1'b0);
    applyStimulus(1'b1, 'h13, 0, 0, 0, 0, 0, 1'b0, 1'b0);

    checkOutput("reset.wbRegwrite", 32'(rwA), 32'd0);
    checkOutput("reset.stallCnt",   32'(cntA), 32'd0);
    checkOutput("reset.exAluop",    32'(aluopB), 32'd0);

    issue('h33, 0, 0, 1, 2, 3, 1'b0);                 // add x3,x1,x2
    nops(4);
    issue('h03, 2, 0, 1, 0, 5, 1'b0);                 // lw x5,0(x1)
    issue('h33, 0, 0, 5, 2, 6, 1'b0);                 // add x6,x5,x2
    nops(3);
    issue('h33, 0, 0, 1, 2, 4, 1'b0);                 // add x4,x1,x2
    issue('h33, 0, 'h20, 4, 4, 7, 1'b0);              // sub x7,x4,x4
    nops(3);
    issue('h33, 0, 0, 1, 2, 0, 1'b0);                 // add x0,x1,x2
    issue('h33, 0, 0, 0, 0, 8, 1'b0);                 // add x8,x0,x0
    nops(3);
    issue('h63, 0, 0, 1, 2, 0, 1'b0);                 // beq
    issue('h33, 0, 0, 1, 1, 9, 1'b1);                 // wrong-path add
    issue('h63, 1, 0, 1, 2, 0, 1'b0);                 // bne
    issue('h33, 0, 0, 1, 1, 9, 1'b1);
    issue('h6F, 0, 0, 0, 0, 1, 1'b0);                 // jal x1
    issue('h33, 0, 0, 1, 1, 2, 1'b0);
    issue('h67, 0, 0, 2, 0, 1, 1'b0);                 // jalr x1,0(x2)
    issue('h03, 2, 0, 1, 0, 3, 1'b0);
    issue('h7F, 0, 0, 1, 2, 3, 1'b0);                 // unknown opcode
    nops(3);

    applyStimulus(1'b1, 'h13, 0, 0, 0, 0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      issue('h03, 2, 0, 2, 0, 1, 1'b0);               // lw x1,0(x2)
      issue('h33, 0, 0, 1, 1, 3, 1'b0);               // add x3,x1,x1
    end
    checkOutput("sat.cntA", 32'(cntA), 32'd5);
    checkOutput("sat.cntB", 32'(cntB), 32'd3);
    applyStimulus(1'b1, 'h13, 0, 0, 0, 0, 0, 1'b0, 1'b1);
    @(posedge clk); #1;
    checkOutput("rst.cntA",   32'(cntA), 32'd0);
    checkOutput("rst.cntB",   32'(cntB), 32'd0);
    checkOutput("rst.exRdA",  32'(exrdA), 32'd0);
    checkOutput("rst.aluopA", 32'(aluopA), 32'd0);
    checkOutput("rst.memRdB", 32'(memrdB), 32'd0);
    checkOutput("rst.wbRdA",  32'(wbrdA), 32'd0);

    for (int n = 0; n < 800; n++) begin
      int sel, o, f3v, f7v, r1, r2, rdv;
      bit z;
      sel = $urandom_range(0, 10);
      r1  = pickReg(); r2 = pickReg(); rdv = pickReg();
      f7v = $urandom_range(0, 1) ? 'h20 : 0;
      f3v = f3Tab[$urandom_range(0, 6)];
      z   = 1'($urandom_range(0, 1));
      case (sel)
        0, 1: o = 'h33;
        2:    o = 'h13;
        3:    begin o = 'h03; f3v = 2; end
        4:    begin o = 'h23; f3v = 2; end
        5:    begin o = 'h63; f3v = 0; end
        6:    begin o = 'h63; f3v = 1; end
        7:    begin o = 'h63; f3v = $urandom_range(2, 7); end
        8:    o = 'h6F;
        9:    begin o = 'h67; f3v = 0; end
        default: o = ($urandom_range(0, 1) != 0) ? 'h7F : 'h37;
      endcase
      if ($urandom_range(0, 59) == 0) applyStimulus(1'b1, o, f3v, f7v, r1, r2, rdv, z, 1'b1);
      else                            issue(o, f3v, f7v, r1, r2, rdv, z);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
